// File: rtl/alu_issue_if.sv
// Request/response and alu16 operand bus for alu_issue_ctrl.
// With ALU_ACC_EN defined, the request also carries req_use_acc.
interface alu_issue_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OPW-1:0]   req_op;
`ifdef ALU_ACC_EN
  logic             req_use_acc;
`endif
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_s;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             busy;

`ifdef ALU_ACC_EN
  modport master (
    output req_valid, req_a, req_b, req_op, req_use_acc, rsp_ready, alu_s,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_use_acc, rsp_ready, alu_s,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, busy
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_s,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_s,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, busy
  );
`endif
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to a combinational alu16, waits SETTLE_CYCLES, returns result.
// Optional accumulator operand source enabled by defining ALU_ACC_EN.
module alu_issue_ctrl #(
  parameter int WIDTH         = 16,
  parameter int OPW           = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic     clk,
  input  logic     reset,
  alu_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             vld_q, vld_d;
`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    vld_d   = vld_q;
`ifdef ALU_ACC_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d = bus.req_a;
`ifdef ALU_ACC_EN
          if (bus.req_use_acc) a_d = acc_q;
`endif
          b_d     = bus.req_b;
          op_d    = bus.req_op;
          cnt_d   = 4'(SETTLE_CYCLES);
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        // Operand regs have been stable for SETTLE_CYCLES edges by the time cnt reaches 1.
        if (cnt_q == 4'd1) begin
          res_d   = bus.alu_s;
          zero_d  = (bus.alu_s == '0);
          vld_d   = 1'b1;
`ifdef ALU_ACC_EN
          acc_d   = bus.alu_s;
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ALU_ACC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances with SETTLE_CYCLES = 1, 2, 3 (index k -> k+1),
// stub alu16 computing a + b + op, directed and random transactions against a reference model.
module tb_alu_issue_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        rv[N], rr[N];
  logic [15:0] ra[N], rb[N];
  logic [2:0]  rop[N];
`ifdef ALU_ACC_EN
  logic        ua[N];
`endif
  logic        rdy[N], rspv[N], zero[N], busy[N];
  logic [15:0] res[N], aa[N], ab[N];
  logic [2:0]  aop[N];

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] acc_m[N];

  for (genvar k = 0; k < N; k++) begin : g
    alu_issue_if #(.WIDTH(16), .OPW(3)) ifc ();
    assign ifc.req_valid = rv[k];
    assign ifc.req_a     = ra[k];
    assign ifc.req_b     = rb[k];
    assign ifc.req_op    = rop[k];
    assign ifc.rsp_ready = rr[k];
`ifdef ALU_ACC_EN
    assign ifc.req_use_acc = ua[k];
`endif
    assign ifc.alu_s = ifc.alu_a + ifc.alu_b + 16'(ifc.alu_op);
    assign rdy[k]  = ifc.req_ready;
    assign rspv[k] = ifc.rsp_valid;
    assign zero[k] = ifc.rsp_zero;
    assign busy[k] = ifc.busy;
    assign res[k]  = ifc.rsp_result;
    assign aa[k]   = ifc.alu_a;
    assign ab[k]   = ifc.alu_b;
    assign aop[k]  = ifc.alu_op;
    alu_issue_ctrl #(.WIDTH(16), .OPW(3), .SETTLE_CYCLES(k + 1)) dut (
      .clk(clk), .reset(reset), .bus(ifc)
    );
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One full transaction; bp = cycles rsp_ready is held low once the response is up.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic u, input int bp);
    logic [15:0] ea, er;
    logic ue;
    int cyc;
`ifdef ALU_ACC_EN
    ue = u;
`else
    ue = 1'b0 & u;
`endif
    ea = ue ? acc_m[k] : a;
    er = ea + b + 16'(op);
    @(negedge clk);
    chk("idle_ready", k, 32'(rdy[k]), 1);
    rv[k] = 1'b1; ra[k] = a; rb[k] = b; rop[k] = op;
`ifdef ALU_ACC_EN
    ua[k] = u;
`endif
    rr[k] = (bp == 0);
    @(negedge clk);
    rv[k] = 1'b0; ra[k] = 16'($urandom); rb[k] = 16'($urandom); rop[k] = 3'($urandom);
    chk("accept_busy", k, 32'(busy[k]), 1);
    chk("alu_a", k, 32'(aa[k]), 32'(ea));
    chk("alu_b", k, 32'(ab[k]), 32'(b));
    cyc = 0;
    while (!rspv[k] && cyc < 20) begin
      chk("alu_op_exec", k, 32'(aop[k]), 32'(op));
      @(negedge clk);
      cyc++;
    end
    chk("latency", k, 32'(cyc), 32'(k + 1));
    chk("result", k, 32'(res[k]), 32'(er));
    chk("zero", k, 32'(zero[k]), 32'(er == 16'h0));
    chk("resp_ready_low", k, 32'(rdy[k]), 0);
    acc_m[k] = er;
    if (bp > 0) begin
      rv[k] = 1'b1; ra[k] = ~a; rb[k] = ~b;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_valid", k, 32'(rspv[k]), 1);
        chk("bp_result", k, 32'(res[k]), 32'(er));
        chk("bp_req_ready", k, 32'(rdy[k]), 0);
        chk("bp_alu_a", k, 32'(aa[k]), 32'(ea));
        chk("bp_alu_op", k, 32'(aop[k]), 32'(op));
      end
      rr[k] = 1'b1;
    end
    @(negedge clk);
    chk("hs_valid_low", k, 32'(rspv[k]), 0);
    chk("hs_idle", k, 32'(busy[k]), 0);
    chk("hs_result_held", k, 32'(res[k]), 32'(er));
    chk("hs_alu_a_held", k, 32'(aa[k]), 32'(ea));
    rv[k] = 1'b0;
    rr[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rv[k] = 0; rr[k] = 0; ra[k] = 0; rb[k] = 0; rop[k] = 0; acc_m[k] = 0;
`ifdef ALU_ACC_EN
      ua[k] = 0;
`endif
    end
    #1 reset = 1'b1;
    #2;
    for (int k = 0; k < N; k++) begin
      chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_valid", k, 32'(rspv[k]), 0);
      chk("rst_zero", k, 32'(zero[k]), 1);
      chk("rst_result", k, 32'(res[k]), 0);
      chk("rst_ready", k, 32'(rdy[k]), 1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of EXEC on the SETTLE=3 instance.
    @(negedge clk);
    rv[2] = 1'b1; ra[2] = 16'h1234; rb[2] = 16'h0001; rop[2] = 3'd2; rr[2] = 1'b1;
    @(negedge clk);
    rv[2] = 1'b0;
    chk("mid_busy", 2, 32'(busy[2]), 1);
    chk("mid_alu_a", 2, 32'(aa[2]), 32'h1234);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 2, 32'(busy[2]), 0);
    chk("mid_rst_valid", 2, 32'(rspv[2]), 0);
    chk("mid_rst_ready", 2, 32'(rdy[2]), 1);
    chk("mid_rst_alu_a", 2, 32'(aa[2]), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) acc_m[k] = 0;
    repeat (6) @(negedge clk);
    chk("mid_no_rsp", 2, 32'(rspv[2]), 0);
    chk("mid_stay_idle", 2, 32'(busy[2]), 0);
    rr[2] = 1'b0;

    // Basic op with SETTLE=1.
    do_op(0, 16'h0014, 16'h0013, 3'd0, 1'b0, 0);
    chk("basic_result", 0, 32'(res[0]), 32'h0027);

    // All opcodes with SETTLE=2.
    for (int op = 0; op < 8; op++) begin
      do_op(1, 16'h0014, 16'h0013, 3'(op), 1'b0, 0);
      chk("op_sweep", 1, 32'(res[1]), 32'h0027 + 32'(op));
    end

    // Backpressure on every instance.
    for (int k = 0; k < N; k++) do_op(k, 16'h0100, 16'h0022, 3'd5, 1'b0, 5);

    // Zero / wrap.
    for (int k = 0; k < N; k++) begin
      do_op(k, 16'hFFFF, 16'h0001, 3'd0, 1'b0, 0);
      chk("wrap_zero", k, {res[k], 15'b0, zero[k]}, 32'h0000_0001);
    end

`ifdef ALU_ACC_EN
    do_op(0, 16'h0005, 16'h0003, 3'd0, 1'b0, 0);
    do_op(0, 16'hBEEF, 16'h0002, 3'd1, 1'b1, 0);
    chk("acc_result", 0, 32'(res[0]), 32'h000B);
`endif

    // Random traffic.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 10; i++) begin
        do_op(k, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
